collision_score: RTL and testbench
==================================

COLLISION_SCORE -- requirements
Module: collision_score

Interface
REQ-001 Parameter SLOTS, default 4: number of enemy slots in enemydata.
REQ-002 Parameter ENEMY_T, default 2'b01: type code of a live enemy; every other code is an empty slot.
REQ-003 Slot layout, fixed, 38 bits: type [1:0], x [11:2], y [21:12], width [29:22], height [37:30]; slot i occupies enemydata[i*38 +: 38].
REQ-004 clk3  in  1  single system clock; all state updates on posedge clk3.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  level; run request from the game controller.
REQ-007 pause  in  1  level; freezes play while high.
REQ-008 enemydata  in  SLOTS*38  slot array produced by the enemy stage.
REQ-009 dino_x, dino_y  in  10 each  dinosaur box origin.
REQ-010 dino_w, dino_h  in  8 each  dinosaur box size.
REQ-011 running  out  1  high in state RUN.
REQ-012 hit  out  1  one-cycle pulse on the detected collision.
REQ-013 gameover  out  1  high in state OVER.
REQ-014 score  out  16  4-digit BCD score.
REQ-015 hiscore  out  16  4-digit BCD best score.

Function
REQ-016 FSM states IDLE, RUN, OVER: IDLE->RUN when start=1, which also clears score and the pipeline; RUN->OVER on a stage-2 collision; OVER->IDLE when start=0; RUN->IDLE when start=0.
REQ-017 Overlap of slot i: type==ENEMY_T and ex<dino_x+dino_w and dino_x<ex+ew and ey<dino_y+dino_h and dino_y<ey+eh; sums in 11 bits, no wrap.
REQ-018 Exit of slot i: registered previous type was ENEMY_T and current type is not ENEMY_T.
REQ-019 Stage 1 (every clock in RUN, pause=0): register the SLOTS-bit overlap vector and exit vector; the previous-type register is updated every clock regardless of state.
REQ-020 Stage 2: if any registered overlap bit is set, pulse hit for one cycle and enter OVER; total latency from input change to hit is 2 clocks.
REQ-021 Stage 2: add the popcount of the registered exit vector to score in BCD with per-digit carry; saturate at 9999.
REQ-022 On the same cycle collision and exits: score is still updated, then OVER is entered.
REQ-023 pause=1 in RUN: stages hold, no hit, score frozen; state unchanged; unpause resumes with fresh stage-1 capture, so there are no stale hits.
REQ-024 In IDLE and OVER, the stage registers are cleared, hit=0, and score holds its last value.
REQ-025 start re-asserted in OVER has no effect until start has been seen low (IDLE).

Reset
REQ-026 reset=0 immediately forces IDLE, running=0, hit=0, gameover=0, score=0, hiscore=0, stage vectors=0, and previous types=0 (empty), including mid-RUN.

Configuration
REQ-027 With HISCORE_EN defined: on the RUN->OVER transition, hiscore loads score if score>hiscore (BCD compare); hiscore survives IDLE and start, and is cleared only by reset.
REQ-028 Without HISCORE_EN: hiscore is constant 0 and no comparator or register exists.

Verification
REQ-029 reset low mid-RUN with score=0x0042 -> all outputs 0 and state IDLE within the same cycle.
REQ-030 start=1; slot0 enemy x=100,y=50,w=20,h=20; dino x=110,y=60,w=16,h=16 -> hit pulses exactly 2 clocks later, gameover=1 the next cycle.
REQ-031 Edge touch: enemy x=126 with dino x=110,w=16 -> no hit; enemy x=125 -> hit.
REQ-032 Slots 0 and 2 go from enemy to empty on the same clock, score=0x0019 -> score=0x0021 two clocks later.
REQ-033 score=0x9999 and one exit -> score stays 0x9999.
REQ-034 HISCORE_EN defined: game over at 0x0030, restart, game over at 0x0012 -> hiscore=0x0030; undefined -> hiscore=0 throughout.

Source files
------------

// File: rtl/collision_score.sv
// collision_score: enemy/dinosaur box collision detection, BCD exit scoring and game FSM (optional hiscore via `HISCORE_EN).
// Latency: input change -> hit after 2 clocks, gameover one clock after hit; slot exits reach score after 2 clocks.
// No backpressure: pause freezes both stages and the score; a fresh stage-1 capture is required after unpause.
module collision_score #(
  parameter int         SLOTS   = 4,     // up to 10 slots: the BCD adder assumes at most one carry per digit
  parameter logic [1:0] ENEMY_T = 2'b01
) (
  input  logic                  clk3,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pause,
  input  logic [SLOTS*38-1:0]   enemydata,
  input  logic [9:0]            dino_x,
  input  logic [9:0]            dino_y,
  input  logic [7:0]            dino_w,
  input  logic [7:0]            dino_h,
  output logic                  running,
  output logic                  hit,
  output logic                  gameover,
  output logic [15:0]           score,
  output logic [15:0]           hiscore
);

  localparam int SW = 38;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [SLOTS-1:0]   ovl_q, ovl_d;
  logic [SLOTS-1:0]   exit_q, exit_d;
  logic               s1_vld_q, s1_vld_d;
  logic               hit_q, hit_d;
  logic [15:0]        score_q, score_d;
  logic [2*SLOTS-1:0] prev_type_q, prev_type_d;

  logic [SLOTS-1:0]   ovl_now;
  logic [SLOTS-1:0]   exit_now;
  logic               act;
  logic [4:0]         exit_cnt;
  logic [4:0]         bcd_dsum;
  logic [4:0]         bcd_carry;
  logic [15:0]        score_sum;
  logic [15:0]        score_sat;

  // Per-slot decode: box overlap in 11-bit arithmetic (no wrap) and enemy->empty exit detection.
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    logic [1:0] e_type;
    logic [9:0] e_x;
    logic [9:0] e_y;
    logic [7:0] e_w;
    logic [7:0] e_h;
    logic       live;

    assign e_type = enemydata[i*SW      +: 2];
    assign e_x    = enemydata[i*SW + 2  +: 10];
    assign e_y    = enemydata[i*SW + 12 +: 10];
    assign e_w    = enemydata[i*SW + 22 +: 8];
    assign e_h    = enemydata[i*SW + 30 +: 8];
    assign live   = (e_type == ENEMY_T);

    assign ovl_now[i] = live
                     && ({1'b0, e_x}    < ({1'b0, dino_x} + {3'b000, dino_w}))
                     && ({1'b0, dino_x} < ({1'b0, e_x}    + {3'b000, e_w}))
                     && ({1'b0, e_y}    < ({1'b0, dino_y} + {3'b000, dino_h}))
                     && ({1'b0, dino_y} < ({1'b0, e_y}    + {3'b000, e_h}));

    assign exit_now[i] = (prev_type_q[2*i +: 2] == ENEMY_T) && !live;
    assign prev_type_d[2*i +: 2] = e_type;
  end

  // Popcount of registered exits added to the score digit by digit, saturating at 9999.
  always_comb begin
    exit_cnt  = '0;
    bcd_dsum  = '0;
    bcd_carry = '0;
    score_sum = '0;
    for (int i = 0; i < SLOTS; i++) begin
      exit_cnt = exit_cnt + 5'(exit_q[i]);
    end
    bcd_carry = exit_cnt;
    for (int d = 0; d < 4; d++) begin
      bcd_dsum = {1'b0, score_q[4*d +: 4]} + bcd_carry;
      if (bcd_dsum >= 5'd10) begin
        score_sum[4*d +: 4] = 4'(bcd_dsum - 5'd10);
        bcd_carry           = 5'd1;
      end else begin
        score_sum[4*d +: 4] = bcd_dsum[3:0];
        bcd_carry           = 5'd0;
      end
    end
    score_sat = (bcd_carry != 5'd0) ? 16'h9999 : score_sum;
  end

  // Game FSM next state plus the two pipeline stages; a pending hit freezes scoring until OVER.
  always_comb begin
    state_d  = state_q;
    ovl_d    = ovl_q;
    exit_d   = exit_q;
    s1_vld_d = 1'b0;
    hit_d    = 1'b0;
    score_d  = score_q;
    act      = (state_q == RUN) && start && !pause && !hit_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          score_d = '0;
        end
      end
      RUN: begin
        if (act) begin
          ovl_d    = ovl_now;
          exit_d   = exit_now;
          s1_vld_d = 1'b1;
          if (s1_vld_q) begin
            hit_d   = |ovl_q;
            score_d = score_sat;
          end
        end
        if (hit_q) begin
          state_d = OVER;
        end else if (!start) begin
          state_d = IDLE;
        end
      end
      OVER: begin
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outside RUN the stages stay empty so a new game never sees old captures.
    if (state_d != RUN) begin
      ovl_d    = '0;
      exit_d   = '0;
      s1_vld_d = 1'b0;
    end
  end

  // State, pipeline and score registers; previous slot types track the input every clock.
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ovl_q       <= '0;
      exit_q      <= '0;
      s1_vld_q    <= 1'b0;
      hit_q       <= 1'b0;
      score_q     <= '0;
      prev_type_q <= '0;
    end else begin
      state_q     <= state_d;
      ovl_q       <= ovl_d;
      exit_q      <= exit_d;
      s1_vld_q    <= s1_vld_d;
      hit_q       <= hit_d;
      score_q     <= score_d;
      prev_type_q <= prev_type_d;
    end
  end

`ifdef HISCORE_EN
  logic [15:0] hiscore_q, hiscore_d;

  // Best score captured on the RUN->OVER edge; BCD digits order the same as binary.
  always_comb begin
    hiscore_d = hiscore_q;
    if ((state_q == RUN) && hit_q && (score_q > hiscore_q)) begin
      hiscore_d = score_q;
    end
  end

  // Hiscore survives games and is cleared only by reset.
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      hiscore_q <= '0;
    end else begin
      hiscore_q <= hiscore_d;
    end
  end

  assign hiscore = hiscore_q;
`else
  assign hiscore = '0;
`endif

  assign running  = (state_q == RUN);
  assign gameover = (state_q == OVER);
  assign hit      = hit_q;
  assign score    = score_q;

endmodule

// File: tb/tb_collision_score.sv
// tb_collision_score: directed scenarios plus randomized play against a cycle-level behavioural model.
// Model works on integer coordinates and a decimal score, converted to BCD only for comparison.
// Outputs are sampled on the falling edge; inputs change on the falling edge after sampling.
module tb_collision_score;

  localparam int         SLOTS   = 4;
  localparam logic [1:0] ENEMY_T = 2'b01;

  logic                clk3 = 1'b0;
  logic                reset;
  logic                start;
  logic                pause;
  logic [SLOTS*38-1:0] enemydata;
  logic [9:0]          dino_x;
  logic [9:0]          dino_y;
  logic [7:0]          dino_w;
  logic [7:0]          dino_h;
  logic                running;
  logic                hit;
  logic                gameover;
  logic [15:0]         score;
  logic [15:0]         hiscore;

  int n_checks = 0;
  int n_errors = 0;

  collision_score #(.SLOTS(SLOTS), .ENEMY_T(ENEMY_T)) dut (
    .clk3      (clk3),
    .reset     (reset),
    .start     (start),
    .pause     (pause),
    .enemydata (enemydata),
    .dino_x    (dino_x),
    .dino_y    (dino_y),
    .dino_w    (dino_w),
    .dino_h    (dino_h),
    .running   (running),
    .hit       (hit),
    .gameover  (gameover),
    .score     (score),
    .hiscore   (hiscore)
  );

  always #5 clk3 = ~clk3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_state;      // 0 idle, 1 run, 2 over
  bit m_hit;
  bit m_v1;         // stage-1 data captured on an active cycle
  bit m_ov1;
  int m_ex1;
  int m_score;      // decimal
  int m_hi;         // decimal
  int m_prev[SLOTS];

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_state = 0; m_hit = 0; m_v1 = 0; m_ov1 = 0; m_ex1 = 0; m_score = 0; m_hi = 0;
    for (int i = 0; i < SLOTS; i++) m_prev[i] = 0;
  endtask

  task automatic model_step();
    int  t, ex, ey, ew, eh, dx, dy, dw, dh;
    bit  ov_now, act, n_hit;
    int  ex_now, n_state, n_score, n_hi;
    ov_now = 0; ex_now = 0;
    dx = int'(dino_x); dy = int'(dino_y); dw = int'(dino_w); dh = int'(dino_h);
    for (int i = 0; i < SLOTS; i++) begin
      t  = int'(enemydata[i*38      +: 2]);
      ex = int'(enemydata[i*38 + 2  +: 10]);
      ey = int'(enemydata[i*38 + 12 +: 10]);
      ew = int'(enemydata[i*38 + 22 +: 8]);
      eh = int'(enemydata[i*38 + 30 +: 8]);
      if (t == int'(ENEMY_T) && ex < dx + dw && dx < ex + ew && ey < dy + dh && dy < ey + eh)
        ov_now = 1;
      if (m_prev[i] == int'(ENEMY_T) && t != int'(ENEMY_T))
        ex_now++;
      m_prev[i] = t;
    end
    act = (m_state == 1) && start && !pause && !m_hit;
    n_state = m_state; n_hit = 0; n_score = m_score; n_hi = m_hi;
    if (act && m_v1) begin
      n_hit   = m_ov1;
      n_score = (m_score + m_ex1 > 9999) ? 9999 : m_score + m_ex1;
    end
    case (m_state)
      0: if (start) begin n_state = 1; n_score = 0; end
      1: begin
        if (m_hit) begin
          n_state = 2;
          if (m_score > m_hi) n_hi = m_score;
        end else if (!start) n_state = 0;
      end
      default: if (!start) n_state = 0;
    endcase
`ifndef HISCORE_EN
    n_hi = 0;
`endif
    m_v1 = act; m_ov1 = ov_now; m_ex1 = ex_now;
    m_state = n_state; m_hit = n_hit; m_score = n_score; m_hi = n_hi;
  endtask

  always @(posedge clk3) if (reset) model_step();

  // ---------------- stimulus helpers ----------------
  task automatic set_slot(input int i, input logic [1:0] t, input int x, input int y, input int w, input int h);
    enemydata[i*38 +: 38] = {8'(h), 8'(w), 10'(y), 10'(x), t};
  endtask

  task automatic tick();
    @(posedge clk3);
    @(negedge clk3);
    check("running",  {31'd0, running},  {31'd0, m_state == 1});
    check("gameover", {31'd0, gameover}, {31'd0, m_state == 2});
    check("hit",      {31'd0, hit},      {31'd0, m_hit});
    check("score",    {16'd0, score},    {16'd0, to_bcd(m_score)});
    check("hiscore",  {16'd0, hiscore},  {16'd0, to_bcd(m_hi)});
  endtask

  // n enemy->empty transitions on far-away slot 3, then flush the pipeline.
  task automatic do_exits(input int n);
    for (int k = 0; k < n; k++) begin
      set_slot(3, ENEMY_T, 900, 0, 10, 10); tick();
      set_slot(3, 2'b00,   900, 0, 10, 10); tick();
    end
    tick(); tick();
  endtask

  task automatic game_over();
    set_slot(0, ENEMY_T, 100, 50, 20, 20);
    tick(); tick(); tick();
    check("go_gameover", {31'd0, gameover}, 32'd1);
    set_slot(0, 2'b00, 0, 0, 0, 0);
  endtask

  logic [15:0] exp_hi;

  initial begin
    reset = 1'b0; start = 1'b0; pause = 1'b0; enemydata = '0;
    dino_x = 10'd110; dino_y = 10'd60; dino_w = 8'd16; dino_h = 8'd16;
    model_reset();
    repeat (2) @(negedge clk3);
    check("rst_running",  {31'd0, running},  32'd0);
    check("rst_gameover", {31'd0, gameover}, 32'd0);
    check("rst_hit",      {31'd0, hit},      32'd0);
    check("rst_score",    {16'd0, score},    32'd0);
    check("rst_hiscore",  {16'd0, hiscore},  32'd0);
    reset = 1'b1;

    // Basic collision: hit exactly two clocks after the enemy appears, OVER one clock later.
    start = 1'b1; tick();
    check("t1_running", {31'd0, running}, 32'd1);
    set_slot(0, ENEMY_T, 100, 50, 20, 20);
    tick(); check("t1_hit_c1", {31'd0, hit}, 32'd0);
    tick(); check("t1_hit_c2", {31'd0, hit}, 32'd1);
            check("t1_go_c2",  {31'd0, gameover}, 32'd0);
    tick(); check("t1_hit_c3", {31'd0, hit}, 32'd0);
            check("t1_go_c3",  {31'd0, gameover}, 32'd1);
    tick(); check("t1_over_hold", {31'd0, gameover}, 32'd1);
    set_slot(0, 2'b00, 0, 0, 0, 0); start = 1'b0; tick();
    check("t1_idle", {31'd0, gameover | running}, 32'd0);

    // Edge touch, then a real overlap held off by pause.
    start = 1'b1; tick();
    set_slot(0, ENEMY_T, 126, 50, 20, 20);
    for (int k = 0; k < 3; k++) begin
      tick(); check("t2_touch_nohit", {31'd0, hit}, 32'd0);
    end
    set_slot(0, ENEMY_T, 125, 50, 20, 20); pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(); check("t2_pause_nohit", {31'd0, hit}, 32'd0);
      check("t2_pause_run", {31'd0, running}, 32'd1);
    end
    pause = 1'b0;
    tick(); check("t2_unpause_c1", {31'd0, hit}, 32'd0);
    tick(); check("t2_unpause_c2", {31'd0, hit}, 32'd1);
    tick(); check("t2_over", {31'd0, gameover}, 32'd1);
    set_slot(0, 2'b00, 0, 0, 0, 0); start = 1'b0; tick();

    // Two simultaneous exits with BCD carry: 19 + 2 = 21.
    start = 1'b1; tick();
    do_exits(19);
    check("t3_score19", {16'd0, score}, 32'h0019);
    set_slot(0, ENEMY_T, 900, 0, 10, 10); set_slot(2, ENEMY_T, 900, 0, 10, 10); tick();
    set_slot(0, 2'b00, 900, 0, 10, 10);   set_slot(2, 2'b00, 900, 0, 10, 10);   tick();
    check("t3_score_c1", {16'd0, score}, 32'h0019);
    tick();
    check("t3_score_c2", {16'd0, score}, 32'h0021);
    start = 1'b0; enemydata = '0; tick();

    // Hiscore keeps the better of two games.
    start = 1'b1; tick();
    do_exits(30);
    game_over();
    check("t4_score30", {16'd0, score}, 32'h0030);
    start = 1'b0; tick();
    start = 1'b1; tick();
    check("t4_restart_clr", {16'd0, score}, 32'h0000);
    do_exits(12);
    game_over();
    check("t4_score12", {16'd0, score}, 32'h0012);
    start = 1'b0; tick();
`ifdef HISCORE_EN
    exp_hi = 16'h0030;
`else
    exp_hi = 16'h0000;
`endif
    check("t4_hiscore", {16'd0, hiscore}, {16'd0, exp_hi});

    // Saturation at 9999.
    start = 1'b1; tick();
    for (int k = 0; k < 2501; k++) begin
      for (int i = 0; i < SLOTS; i++) set_slot(i, ENEMY_T, 900, 0, 10, 10);
      tick();
      for (int i = 0; i < SLOTS; i++) set_slot(i, 2'b00, 900, 0, 10, 10);
      tick();
    end
    tick(); tick();
    check("t5_sat", {16'd0, score}, 32'h9999);
    do_exits(1);
    check("t5_sat_hold", {16'd0, score}, 32'h9999);
    start = 1'b0; enemydata = '0; tick();

    // Randomized play.
    for (int c = 0; c < 3000; c++) begin
      start = ($urandom_range(0, 40) != 0);
      pause = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) begin
        dino_x = 10'($urandom); dino_y = 10'($urandom);
        dino_w = 8'($urandom);  dino_h = 8'($urandom);
      end
      for (int i = 0; i < SLOTS; i++) begin
        if ($urandom_range(0, 3) == 0)
          set_slot(i, ($urandom_range(0, 1) == 1) ? ENEMY_T : 2'($urandom),
                   int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
                   int'($urandom_range(0, 255)),  int'($urandom_range(0, 255)));
      end
      tick();
    end

    // Asynchronous reset in the middle of a game with score 42.
    pause = 1'b0; start = 1'b0; enemydata = '0;
    dino_x = 10'd110; dino_y = 10'd60; dino_w = 8'd16; dino_h = 8'd16;
    tick(); tick();
    start = 1'b1; tick();
    do_exits(42);
    check("t6_score42", {16'd0, score}, 32'h0042);
    check("t6_running", {31'd0, running}, 32'd1);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check("t6_rst_running",  {31'd0, running},  32'd0);
    check("t6_rst_gameover", {31'd0, gameover}, 32'd0);
    check("t6_rst_hit",      {31'd0, hit},      32'd0);
    check("t6_rst_score",    {16'd0, score},    32'd0);
    check("t6_rst_hiscore",  {16'd0, hiscore},  32'd0);
    tick();
    reset = 1'b1;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
